// File: rtl/dm_store_buffer.sv
// dm_store_buffer: in-order store FIFO feeding the DM write port, with youngest-match load forwarding.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [31:0]   st_pc,
  output logic          st_ready,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [31:0]   ld_data,
  input  logic          drain_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic [31:0]   mem_pc,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  logic [AW-1:0] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic          w_push;
  assign st_ready = r_count != CNT_FULL;
  assign empty    = r_count == '0;
  assign w_push   = st_valid && st_ready;
  assign mem_we   = !empty && !drain_stall;
  assign mem_addr = empty ? '0 : r_addr[r_head];
  assign mem_din  = empty ? '0 : r_data[r_head];
  assign mem_pc   = empty ? '0 : r_pc[r_head];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(mem_we);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(mem_we);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_pc[r_tail]   <= st_pc;
    end
  end
  // Scan oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < r_count && r_addr[r_head + PW'(i)] == ld_addr) begin
        ld_hit  = 1'b1;
        ld_data = r_data[r_head + PW'(i)];
      end
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: scoreboard of pending stores checked against DM writes and forwarding.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 10;
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   p;
  } ent_t;
  logic          clk = 0;
  logic          reset;
  logic          st_valid, st_ready, ld_hit, drain_stall, mem_we, empty;
  logic [AW-1:0] st_addr, ld_addr, mem_addr;
  logic [31:0]   st_data, st_pc, ld_data, mem_din, mem_pc;
  ent_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  always #5 clk = ~clk;
  dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .drain_stall(drain_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_pc(mem_pc),
    .empty(empty)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Check outputs mid-cycle against the queue, then apply the edge to the queue.
  task automatic cyc();
    logic        h, we, acc;
    logic [31:0] d;
    ent_t        e;
    @(negedge clk);
    h = 0;
    d = 0;
    foreach (sb[i]) if (sb[i].a == ld_addr) begin h = 1; d = sb[i].d; end
    we  = sb.size() != 0 && !drain_stall;
    acc = st_valid && sb.size() < DEPTH;
    e   = '{a: '0, d: '0, p: '0};
    if (sb.size() != 0) e = sb[0];
    chk("st_ready", st_ready, sb.size() < DEPTH);
    chk("empty", empty, sb.size() == 0);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, e.a);
    chk("mem_din", mem_din, e.d);
    chk("mem_pc", mem_pc, e.p);
    chk("ld_hit", ld_hit, h);
    chk("ld_data", ld_data, d);
    @(posedge clk);
    if (!reset) begin
      if (we) void'(sb.pop_front());
      if (acc) sb.push_back('{a: st_addr, d: st_data, p: st_pc});
    end
    #1;
  endtask
  task automatic put(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1;
    st_addr  = a;
    st_data  = d;
    st_pc    = p;
    cyc();
    st_valid = 0;
  endtask
  initial begin
    reset = 1; st_valid = 0; st_addr = 0; st_data = 0; st_pc = 0;
    ld_addr = 0; drain_stall = 0;
    #3;
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_hit", ld_hit, 0);
    chk("rst_ldata", ld_data, 0);
    @(posedge clk); #1 reset = 0;
    put(10'h004, 32'hDEADBEEF, 32'h00003000);
    repeat (2) cyc();
    drain_stall = 1;
    for (int i = 1; i <= 5; i++) put(AW'(i), 32'h11 * i, 32'h100 + i);
    chk("full_ready", st_ready, 0);
    cyc();
    drain_stall = 0;
    repeat (5) cyc();
    drain_stall = 1;
    put(10'd8, 32'hA, 32'h200);
    put(10'd8, 32'hB, 32'h204);
    ld_addr = 8;
    cyc();
    chk("fwd_young", ld_data, 32'hB);
    ld_addr = 9;
    cyc();
    chk("fwd_miss", ld_hit, 0);
    drain_stall = 0;
    repeat (3) cyc();
    for (int i = 0; i < 10; i++) put(AW'(10'h100 + i), $urandom, 32'h400 + 4 * i);
    repeat (3) cyc();
    drain_stall = 1;
    for (int i = 0; i < 3; i++) put(AW'(10'h40 + i), 32'hC0 + i, 32'h500 + i);
    #2 reset = 1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_we", mem_we, 0);
    sb.delete();
    cyc();
    reset = 0;
    drain_stall = 0;
    repeat (3) cyc();
    drain_stall = 1;
    for (int i = 0; i < 3; i++) put(AW'(10'h20 + i), 32'hE0 + i, 32'h600 + i);
    drain_stall = 0;
    put(10'h030, 32'h77, 32'h700);
    drain_stall = 1;
    ld_addr = 10'h030;
    cyc();
    chk("pp_ready", st_ready, 1);
    chk("pp_fwd", ld_data, 32'h77);
    drain_stall = 0;
    repeat (5) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Initiator-side front end for the data memory. It sits between the MEM stage and the DM write port.
- Accepts store requests from the pipeline, queues them in a small FIFO, and drains them to the DM one per cycle.
- Drives the DM's MemWrite/addr/din/pc inputs directly.
- Forwards queued store data to loads whose address matches a pending store, so that loads see program-order values.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 10, word-address width; matches the DM addr port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- st_valid  input  1  store request from the MEM stage this cycle.
- st_addr  input  AW  word address of the store.
- st_data  input  32  store data.
- st_pc  input  32  PC of the store instruction; carried to the DM for its write trace.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  AW  word address of the current load. Compared every cycle.
- ld_hit  output  1  ld_addr matches a pending entry.
- ld_data  output  32  data of the youngest matching entry; 0 when ld_hit=0.
- drain_stall  input  1  inhibits draining this cycle.
- mem_we  output  1  to DM MemWrite.
- mem_addr  output  AW  to DM addr.
- mem_din  output  32  to DM din.
- mem_pc  output  32  to DM pc.
- empty  output  1  no pending stores; used by the pipeline before halt/trace end.

Behaviour:
- Storage and reset:
  - Circular FIFO with entries {addr, data, pc}.
  - State: head pointer, tail pointer, and count (0..DEPTH).
  - On reset assertion, without waiting for clk: head=0, tail=0, count=0.
  - Therefore st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_data=0.
  - Entries pending at reset are discarded, never written to the DM.
  - Entry payload registers need no reset.
- Accept:
  - st_ready = (count < DEPTH). There is no full-bypass.
  - Push when st_valid && st_ready: write the entry at tail, then tail = tail+1 mod DEPTH.
  - st_valid while st_ready=0: the store is ignored. The pipeline is required to stall and hold the request.
- Drain:
  - mem_we = (count != 0) && !drain_stall.
  - mem_addr, mem_din and mem_pc are combinational from the head entry. They are 0 when count=0.
  - On a clock edge with mem_we=1, the DM performs the write and head advances by 1 mod DEPTH.
  - Minimum latency from store acceptance to DM write is 1 cycle: accepted at edge N, mem_we high during cycle N+1, DM written at edge N+1.
  - Stores reach the DM strictly in acceptance order, one per cycle.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - With count=DEPTH, no push occurs (st_ready=0) even if a pop happens that edge.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full versus empty is decided by count only.
- Load forwarding (combinational):
  - Compare ld_addr against all valid entries, i.e. the count entries from head.
  - On multiple matches, pick the youngest, nearest tail.
  - The head entry being drained this cycle still forwards. After the edge it is in the DM, so there is no gap.
  - A store presented on st_valid in the same cycle is NOT forwarded. The hazard unit resolves same-cycle store/load overlap.
- drain_stall held high: the queue fills to DEPTH, st_ready drops, and forwarding remains correct.

Test Plan:
- Reset, then one store addr=0x004 data=0xDEADBEEF pc=0x00003000 at edge 1 -> cycle 2: mem_we=1, mem_addr=0x004, mem_din=0xDEADBEEF, mem_pc=0x00003000; after edge 2: empty=1, mem_we=0.
- drain_stall=1; push 4 stores to addrs 1,2,3,4 with data 0x11..0x44 -> st_ready=0 after the 4th; a 5th store with data 0x55 is ignored. Release the stall -> DM writes in order 0x11,0x22,0x33,0x44 on 4 consecutive edges; 0x55 is never written.
- drain_stall=1; stores addr=8 data=0xA then addr=8 data=0xB; ld_addr=8 -> ld_hit=1, ld_data=0xB. ld_addr=9 -> ld_hit=0, ld_data=0.
- Continuous push every cycle with no stall, 10 stores -> count stays at 1 after the first, no store is dropped, and the pointers wrap past DEPTH. The DM sees all 10 in order.
- Fill 3 entries under stall, then assert reset asynchronously mid-cycle -> empty=1 and mem_we=0 immediately. No DM write occurs after reset deasserts.
- Simultaneous push and pop at count=3 -> count remains 3; the head entry is written, and the new entry appears at the tail and is forwarded on ld_addr match the next cycle.
